lcd_refresh_spi: RTL
====================

// Module: lcd_refresh_spi
// PURPOSE
//  Read side of the 128x64 LCD frame RAM (1024 x 8, 8 pages x 128 cols, 1-cycle registered read).
//  On start, scans the whole RAM page by page and streams it to an ST7565-class LCD over 4-wire SPI.
//  Per page: 3 command bytes (set page, col hi, col lo) then 128 data bytes; 1048 bytes/frame.
//  Sits between the frame RAM read port and the LCD pins; RAM writes are not blocked (tearing allowed).
// PARAMETERS
//  CLK_DIV   4    sys_clk cycles per SPI half-period (>=1); SPI bit = 2*CLK_DIV cycles
//  PAGES     8    LCD pages (8 rows each)
//  COLS      128  columns per page
// PORTS
//  sys_clk      in   1   system clock, all logic on rising edge
//  sys_rst_n    in   1   synchronous active-low reset
//  start        in   1   begin one frame refresh; sampled only in IDLE
//  busy         out  1   high from first cycle after accepted start until frame_done
//  frame_done   out  1   one-cycle pulse after last bit of byte 1048
//  ram_addr_r   out  10  frame RAM read address
//  ram_data_r   in   8   frame RAM read data, valid 1 cycle after ram_addr_r
//  lcd_cs_n     out  1   SPI chip select, low for the whole frame
//  lcd_sclk     out  1   SPI clock, mode 0 (idle low, sample on rising)
//  lcd_mosi     out  1   SPI data, MSB first
//  lcd_dc       out  1   0 = command byte, 1 = display data byte; stable for whole byte
// BEHAVIOUR
//  Reset (sys_rst_n=0 at an edge): busy=0, frame_done=0, ram_addr_r=0, lcd_cs_n=1, lcd_sclk=0,
//   lcd_mosi=0, lcd_dc=0, FSM=IDLE, page/col counters=0. Applies mid-frame; no partial-byte completion.
//  Address map (fixed): ram_addr_r = {page[2:1], col[6:0], page[0]}.
//  FSM: IDLE -> (start) CMD -> SHIFT -> ... ; states IDLE, CMD, RD_REQ, RD_WAIT, SHIFT, NEXT, DONE.
//   IDLE: start=1 -> CMD, cs_n falls, busy rises, page=0, cmd_idx=0.
//   CMD: load byte: idx0 = 8'hB0|page, idx1 = 8'h10, idx2 = 8'h00; dc=0; -> SHIFT.
//   RD_REQ: drive ram_addr_r for (page,col) -> RD_WAIT; RD_WAIT: latch ram_data_r, dc=1 -> SHIFT.
//   SHIFT: 8 bits; mosi updated only while sclk low; sclk high for CLK_DIV, low for CLK_DIV.
//   NEXT: cmd_idx<2 -> CMD; cmd done or col<COLS-1 -> RD_REQ (col++ after first);
//    col=COLS-1 & page<PAGES-1 -> page++, col=0, CMD; last byte -> DONE.
//   DONE: cs_n=1, busy=0, frame_done=1 for one cycle -> IDLE.
//  Inter-byte gap: sclk low, cs_n low, at most 3 sys_clk (NEXT + CMD or RD_REQ+RD_WAIT).
//  start while busy: ignored. start held high: new frame begins the cycle after DONE->IDLE.
//  Counters: page 3 bit, col 7 bit, bit count 3 bit, divider $clog2(CLK_DIV)+1 bit; no wrap beyond
//   PAGES/COLS (terminal values checked explicitly).
//  No outputs are X after reset; ram_addr_r holds last value when not fetching.
// STRUCTURE
//  Package lcd_pkg: LCD_PAGES, LCD_COLS, CMD_SET_PAGE=8'hB0, CMD_COL_HI=8'h10, CMD_COL_LO=8'h00,
//   function lcd_addr(page,col) implementing the address map (shared with RAM writers).
//  Sub-module spi_byte_tx: load/byte in, done pulse out, owns divider, sclk, mosi, bit counter.
//  Top: FSM, page/col/cmd counters, RAM address, dc, cs_n, busy, frame_done.
// TESTING (CLK_DIV=2, behavioural RAM model with 1-cycle read latency)
//  1 Reset, RAM[a]=a[7:0], pulse start -> bytes 0xB0,0x10,0x00 with dc=0, then 0x00,0x02,0x04 dc=1.
//  2 Page 5 col 3 fetch -> ram_addr_r=10'h207; byte on MOSI = 8'h07 with RAM[a]=a[7:0].
//  3 Full frame -> exactly 1048 bytes, 24 command bytes; frame_done one cycle; busy falls; cs_n=1.
//  4 SPI checker -> sclk period 4 cycles, mosi never changes while sclk high, MSB first, gap<=3.
//  5 start pulsed mid-frame -> ignored (byte count 1048); start held high -> second frame follows.
//  6 sys_rst_n low during byte 500 -> next edge all reset values; new start restarts at 0xB0, addr 0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared LCD geometry, ST7565 command bytes, state encoding and the frame RAM address map.
package lcd_pkg;

   localparam int unsigned LCD_PAGES = 8;
   localparam int unsigned LCD_COLS  = 128;
   localparam int unsigned PAGE_W    = 3;
   localparam int unsigned COL_W     = 7;
   localparam int unsigned ADDR_W    = 10;

   localparam logic [7:0] CMD_SET_PAGE = 8'hB0;
   localparam logic [7:0] CMD_COL_HI   = 8'h10;
   localparam logic [7:0] CMD_COL_LO   = 8'h00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_SHIFT,
      ST_NEXT,
      ST_DONE
   } lcd_state_e;

   // Page bits straddle the column so RAM writers and this reader agree on one layout.
   function automatic logic [ADDR_W-1:0] lcd_addr(input logic [PAGE_W-1:0] page,
                                                  input logic [COL_W-1:0]  col);
      return {page[2:1], col, page[0]};
   endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// SPI mode-0 byte shifter, MSB first; done_c marks the clock edge on which the last sclk falls.
module spi_byte_tx #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] data,
   output logic       sclk,
   output logic       mosi,
   output logic       done_c
);

   localparam int unsigned DIV_W = $clog2(CLK_DIV) + 1;

   logic             active;
   logic [DIV_W-1:0] div_cnt;
   logic [2:0]       bit_cnt;
   logic [6:0]       sh;
   logic             phase_end_c;

   assign phase_end_c = active && (div_cnt == DIV_W'(CLK_DIV - 1));
   assign done_c      = phase_end_c && sclk && (bit_cnt == 3'd7);

   // mosi only moves on load or together with the falling sclk edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         active  <= 1'b0;
         div_cnt <= '0;
         bit_cnt <= '0;
         sh      <= '0;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
      end else if (load) begin
         active  <= 1'b1;
         div_cnt <= '0;
         bit_cnt <= '0;
         sh      <= data[6:0];
         sclk    <= 1'b0;
         mosi    <= data[7];
      end else if (active) begin
         if (phase_end_c) begin
            div_cnt <= '0;
            if (!sclk) begin
               sclk <= 1'b1;
            end else begin
               sclk <= 1'b0;
               if (bit_cnt == 3'd7) begin
                  active <= 1'b0;
               end else begin
                  bit_cnt <= bit_cnt + 3'd1;
                  mosi    <= sh[6];
                  sh      <= {sh[5:0], 1'b0};
               end
            end
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/lcd_refresh_spi.sv
// Streams the 128x64 frame RAM to an ST7565-class LCD: per page three command bytes, then all columns.
module lcd_refresh_spi
   import lcd_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned PAGES   = LCD_PAGES,
   parameter int unsigned COLS    = LCD_COLS
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              start,
   output logic              busy,
   output logic              frame_done,
   output logic [ADDR_W-1:0] ram_addr_r,
   input  logic [7:0]        ram_data_r,
   output logic              lcd_cs_n,
   output logic              lcd_sclk,
   output logic              lcd_mosi,
   output logic              lcd_dc
);

   lcd_state_e        state_q, state_d;
   logic [PAGE_W-1:0] page_q, page_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [1:0]        cmd_idx_q, cmd_idx_d;   // 0..2 command bytes, 3 = data phase of the page
   logic [ADDR_W-1:0] addr_d;
   logic              dc_d, cs_n_d, busy_d, frame_done_d;
   logic              load_c, tx_done_c;
   logic [7:0]        tx_byte_c, cmd_byte_c;

   spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
      .clk    (sys_clk),
      .rst_n  (sys_rst_n),
      .load   (load_c),
      .data   (tx_byte_c),
      .sclk   (lcd_sclk),
      .mosi   (lcd_mosi),
      .done_c (tx_done_c)
   );

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q    <= ST_IDLE;
         page_q     <= '0;
         col_q      <= '0;
         cmd_idx_q  <= '0;
         ram_addr_r <= '0;
         lcd_dc     <= 1'b0;
         lcd_cs_n   <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         page_q     <= page_d;
         col_q      <= col_d;
         cmd_idx_q  <= cmd_idx_d;
         ram_addr_r <= addr_d;
         lcd_dc     <= dc_d;
         lcd_cs_n   <= cs_n_d;
         busy       <= busy_d;
         frame_done <= frame_done_d;
      end
   end

   always_comb begin
      cmd_byte_c = CMD_COL_LO;
      case (cmd_idx_q)
         2'd0:    cmd_byte_c = CMD_SET_PAGE | 8'(page_q);
         2'd1:    cmd_byte_c = CMD_COL_HI;
         default: cmd_byte_c = CMD_COL_LO;
      endcase
   end

   // Next state, counters and next values of the registered outputs
   always_comb begin
      state_d      = state_q;
      page_d       = page_q;
      col_d        = col_q;
      cmd_idx_d    = cmd_idx_q;
      addr_d       = ram_addr_r;
      dc_d         = lcd_dc;
      cs_n_d       = lcd_cs_n;
      busy_d       = busy;
      frame_done_d = 1'b0;
      load_c       = 1'b0;
      tx_byte_c    = cmd_byte_c;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_CMD;
               cs_n_d    = 1'b0;
               busy_d    = 1'b1;
               page_d    = '0;
               col_d     = '0;
               cmd_idx_d = '0;
            end
         end
         ST_CMD: begin
            load_c  = 1'b1;
            dc_d    = 1'b0;
            state_d = ST_SHIFT;
         end
         ST_RD_REQ: begin
            state_d = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            load_c    = 1'b1;
            tx_byte_c = ram_data_r;
            dc_d      = 1'b1;
            state_d   = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (tx_done_c) state_d = ST_NEXT;
         end
         ST_NEXT: begin
            if (cmd_idx_q < 2'd2) begin
               cmd_idx_d = cmd_idx_q + 2'd1;
               state_d   = ST_CMD;
            end else if (cmd_idx_q == 2'd2) begin
               cmd_idx_d = 2'd3;
               col_d     = '0;
               addr_d    = lcd_addr(page_q, '0);
               state_d   = ST_RD_REQ;
            end else if (col_q != COL_W'(COLS - 1)) begin
               col_d   = col_q + COL_W'(1);
               addr_d  = lcd_addr(page_q, col_q + COL_W'(1));
               state_d = ST_RD_REQ;
            end else if (page_q != PAGE_W'(PAGES - 1)) begin
               page_d    = page_q + PAGE_W'(1);
               col_d     = '0;
               cmd_idx_d = '0;
               state_d   = ST_CMD;
            end else begin
               cs_n_d       = 1'b1;
               busy_d       = 1'b0;
               frame_done_d = 1'b1;
               state_d      = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule
